spi_sensor_packet_rx: RTL and testbench
=======================================

Name: spi_sensor_packet_rx

Overview:
- Parametrised, single-clock successor to the read-only Arduino SPI receiver.
- The Arduino (SPI master, Mode 0, MSB first) sends one packet per CS-low transaction.
- SCK, CS and MOSI are oversampled in the clk domain. Packets carry NUM_CH sensor channels, a sequence number and an XOR checksum.
- Validated fields are committed atomically to per-channel output registers, which feed the orientation/graphics pipeline. Error and statistics counters are exposed for debug LEDs.

Parameters:
- NUM_CH, 1: sensor channels per packet (1..4).
- HEADER_BYTE, 8'hAA: required first byte.
- SYNC_STAGES, 2: synchronizer depth for cs_n, sck and sdi (≥2).
- CSUM_EN, 1: 1 = check the checksum byte; 0 = accept any checksum byte.
- Derived: PKT_BYTES = 3 + 13·NUM_CH.

Ports:
- clk  in  1  system clock; f_clk ≥ 8·f_sck
- rst_n  in  1  asynchronous, active-low reset
- cs_n  in  1  chip select from Arduino, async, active low
- sck  in  1  SPI clock, async
- sdi  in  1  MOSI, async
- euler  out  48·NUM_CH  per channel {roll,pitch,yaw}, signed 16b each; channel k at [48k+47:48k], roll in the MSBs
- gyro  out  48·NUM_CH  per channel {x,y,z}, same packing
- euler_valid  out  NUM_CH  flags bit0 per channel
- gyro_valid  out  NUM_CH  flags bit1 per channel
- seq_num  out  8  sequence byte of the last good packet
- pkt_strobe  out  1  1-cycle pulse on each commit
- seq_gap  out  1  1-cycle pulse, coincident with pkt_strobe, when a sequence was skipped
- initialized  out  1  set by the first good packet
- error  out  1  1 = last completed transaction was bad
- good_cnt  out  16  good packets, wraps
- err_hdr_cnt, err_len_cnt, err_csum_cnt  out  8 each  saturating at 255

Behaviour:
- Reset (rst_n=0):
  - All outputs 0; state IDLE; staging buffer, byte/bit counters and running XOR cleared.
  - Synchronizer flops reset to cs_n=1, sck=0, sdi=0.
- Input synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - Edges are detected on the synchronized signals against a one-cycle-delayed copy.
  - sck_rise and cs_fall/cs_rise are single-cycle pulses.
- Packet format (bytes):
  - 0: header.
  - 1: sequence number.
  - Per channel k, base 2+13k: roll, pitch, yaw, gx, gy, gz as big-endian int16, then a flags byte.
  - Last byte: checksum = XOR of bytes 0..PKT_BYTES-2.
- State machine:
  - IDLE: on cs_fall → RECV. Byte and bit counters and XOR are zeroed.
    - After reset with cs_n already low, the block stays in IDLE until a full cs_n high→low cycle.
  - RECV: on sck_rise, shift sdi into the LSB of an 8-bit shift register. On the 8th bit, store the completed byte.
    - Byte 0 ≠ HEADER_BYTE → DISCARD.
    - Bytes with index ≥ PKT_BYTES are not stored; an over-length flag is set.
    - On cs_rise → EVAL.
  - DISCARD: ignore sck; on cs_rise → EVAL.
  - EVAL (one cycle), exactly one outcome per transaction, in priority order:
    1. Header bad, or 0 bytes received: err_hdr_cnt++.
    2. Byte count ≠ PKT_BYTES, a partial byte pending (bit_cnt≠0), or over-length: err_len_cnt++.
    3. CSUM_EN and running XOR of all PKT_BYTES bytes ≠ 0: err_csum_cnt++.
    4. Otherwise: commit.
  - After EVAL → IDLE.
- Commit (registered on the cycle after EVAL):
  - euler, gyro, valids and seq_num are loaded from the staging buffer all on the same edge.
  - pkt_strobe=1; good_cnt++; initialized=1; error=0.
  - Bad outcomes set error=1 and leave the data outputs untouched. Consumers never see a torn packet.
- seq_gap: asserted on commit when seq ≠ (previous committed seq + 1) mod 256. It is not asserted on the first commit after reset. 8'hFF→8'h00 is not a gap.
- Latency: pkt_strobe rises SYNC_STAGES+3 clk cycles after cs_n rises at the pin (±1 cycle for synchronizer phase).
- cs_rise and sck_rise in the same cycle: the sck edge is discarded and the transaction is evaluated.
- Asynchronous reset mid-packet: the partial packet is abandoned silently, with no counter increment.

Test Plan:
- NUM_CH=2 (PKT_BYTES=29). Good packet: 0xAA, seq 0x05, ch0 roll=0x1234, pitch=0xFF00, yaw=0x0001, gyro=0x0102/0x0304/0x0506, flags=0x03; ch1 all 0x8000 with flags=0x01; correct checksum. Required: pkt_strobe once; euler[47:0]=0x1234FF000001; euler_valid=2'b11; gyro_valid=2'b01; good_cnt=1; initialized=1; seq_gap=0.
- Bad header: header 0x55, 29 bytes sent. Required: err_hdr_cnt=1, error=1, outputs unchanged, no pkt_strobe.
- Length errors: 28 bytes, then a packet with 3 extra bits after 29 bytes. Required: err_len_cnt=2, no commit.
- Checksum: flip bit 0 of the checksum. Required: err_csum_cnt=1. Repeat with CSUM_EN=0: commit occurs.
- Sequence: seq 0x05, 0x06, 0x08, 0xFF, 0x00. Required: seq_gap pulses only on 0x08 and 0xFF.
- Resets: assert rst_n low at byte 10 while cs_n is still low, then release. Required: no counter change; the rest of that transaction is ignored; the next full packet commits. Send 300 bad-header packets: err_hdr_cnt saturates at 255.

Source files
------------

// File: rtl/spi_sensor_packet_rx.sv
// spi_sensor_packet_rx
// Oversampled SPI (Mode 0, MSB first) packet receiver for the Arduino sensor link.
// One packet per CS-low transaction: header, sequence, NUM_CH x 13-byte channel
// records and an XOR checksum. Good packets are committed atomically to the
// per-channel output registers; bad ones only bump a saturating error counter.

module spi_sensor_packet_rx #(
    parameter int unsigned NUM_CH      = 1,
    parameter logic [7:0]  HEADER_BYTE = 8'hAA,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          CSUM_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic                  sck,
    input  logic                  sdi,
    output logic [48*NUM_CH-1:0]  euler,
    output logic [48*NUM_CH-1:0]  gyro,
    output logic [NUM_CH-1:0]     euler_valid,
    output logic [NUM_CH-1:0]     gyro_valid,
    output logic [7:0]            seq_num,
    output logic                  pkt_strobe,
    output logic                  seq_gap,
    output logic                  initialized,
    output logic                  error,
    output logic [15:0]           good_cnt,
    output logic [7:0]            err_hdr_cnt,
    output logic [7:0]            err_len_cnt,
    output logic [7:0]            err_csum_cnt
);

    localparam int unsigned     PKT_BYTES = 3 + 13 * NUM_CH;
    // Header and checksum bytes are never needed after reception, so only the
    // sequence byte and channel records are staged.
    localparam int unsigned     PAY_BYTES = PKT_BYTES - 2;
    localparam int unsigned     CNT_W     = $clog2(PKT_BYTES + 1);
    localparam logic [CNT_W-1:0] PKT_LEN  = CNT_W'(PKT_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD,
        EVAL
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES:0]   sync_vld;
    logic                   cs_s;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   cs_d;
    logic                   sck_d;
    logic                   edges_ok;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_rise;

    state_t                 state;
    logic [CNT_W-1:0]       byte_cnt;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift_q;
    logic [7:0]             xor_acc;
    logic                   hdr_bad;
    logic                   over_len;
    logic [7:0]             pay [PAY_BYTES];
    logic [7:0]             rx_byte;

    // Synchronize the async pins and keep one-cycle-delayed copies for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
            sync_vld <= '0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
            sync_vld <= {sync_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    // Edges are only trusted once both the synchronized value and its delayed
    // copy hold real pin samples; otherwise the reset value of the chain would
    // fake a CS fall when cs_n is already low as reset is released.
    assign edges_ok = sync_vld[SYNC_STAGES];
    assign cs_fall  = edges_ok & cs_d & ~cs_s;
    assign cs_rise  = edges_ok & ~cs_d & cs_s;
    assign sck_rise = edges_ok & sck_s & ~sck_d;

    // Byte being completed on this sck edge (MSB first, new bit into the LSB)
    assign rx_byte = {shift_q, sdi_s};

    // Receive FSM, transaction evaluation and registered commit of outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            xor_acc      <= '0;
            hdr_bad      <= 1'b0;
            over_len     <= 1'b0;
            for (int unsigned i = 0; i < PAY_BYTES; i++) begin
                pay[i] <= '0;
            end
            euler        <= '0;
            gyro         <= '0;
            euler_valid  <= '0;
            gyro_valid   <= '0;
            seq_num      <= '0;
            pkt_strobe   <= 1'b0;
            seq_gap      <= 1'b0;
            initialized  <= 1'b0;
            error        <= 1'b0;
            good_cnt     <= '0;
            err_hdr_cnt  <= '0;
            err_len_cnt  <= '0;
            err_csum_cnt <= '0;
        end else begin
            pkt_strobe <= 1'b0;
            seq_gap    <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= RECV;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        xor_acc  <= '0;
                        hdr_bad  <= 1'b0;
                        over_len <= 1'b0;
                    end
                end

                RECV: begin
                    // CS release wins over a coincident sck edge
                    if (cs_rise) begin
                        state <= EVAL;
                    end else if (sck_rise) begin
                        shift_q <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == PKT_LEN) begin
                                over_len <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + CNT_W'(1);
                                xor_acc  <= xor_acc ^ rx_byte;
                                for (int unsigned i = 0; i < PAY_BYTES; i++) begin
                                    if (32'(byte_cnt) == i + 1) begin
                                        pay[i] <= rx_byte;
                                    end
                                end
                                if (byte_cnt == '0 && rx_byte != HEADER_BYTE) begin
                                    hdr_bad <= 1'b1;
                                    state   <= DISCARD;
                                end
                            end
                        end
                    end
                end

                DISCARD: begin
                    if (cs_rise) begin
                        state <= EVAL;
                    end
                end

                EVAL: begin
                    state <= IDLE;
                    if (hdr_bad || byte_cnt == '0) begin
                        error <= 1'b1;
                        if (err_hdr_cnt != '1) begin
                            err_hdr_cnt <= err_hdr_cnt + 8'd1;
                        end
                    end else if (byte_cnt != PKT_LEN || bit_cnt != '0 || over_len) begin
                        error <= 1'b1;
                        if (err_len_cnt != '1) begin
                            err_len_cnt <= err_len_cnt + 8'd1;
                        end
                    end else if (CSUM_EN && xor_acc != '0) begin
                        error <= 1'b1;
                        if (err_csum_cnt != '1) begin
                            err_csum_cnt <= err_csum_cnt + 8'd1;
                        end
                    end else begin
                        // pay[i] holds packet byte i+1; channel k record starts at pay[13k+1]
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            for (int unsigned j = 0; j < 6; j++) begin
                                euler[48*k + 40 - 8*j +: 8] <= pay[13*k + 1 + j];
                                gyro[48*k + 40 - 8*j +: 8]  <= pay[13*k + 7 + j];
                            end
                            euler_valid[k] <= pay[13*k + 13][0];
                            gyro_valid[k]  <= pay[13*k + 13][1];
                        end
                        seq_num     <= pay[0];
                        seq_gap     <= initialized && (pay[0] != seq_num + 8'd1);
                        pkt_strobe  <= 1'b1;
                        good_cnt    <= good_cnt + 16'd1;
                        initialized <= 1'b1;
                        error       <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sensor_packet_rx.sv
// Self-checking bench for spi_sensor_packet_rx with NUM_CH=2.
// Two instances share the SPI pins: one checks the checksum, one ignores it.
// A packet-level model predicts every output; a per-cycle compare process
// checks the DUTs against it, and directed literals pin the model.

module tb_spi_sensor_packet_rx;

    localparam int NCH  = 2;
    localparam int PB   = 3 + 13 * NCH;
    localparam int SS   = 2;
    localparam int HALF = 4;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n  = 1'b1;
    logic sck   = 1'b0;
    logic sdi   = 1'b0;

    always #5 clk = ~clk;

    logic [48*NCH-1:0] euler [2];
    logic [48*NCH-1:0] gyro  [2];
    logic [NCH-1:0]    ev    [2];
    logic [NCH-1:0]    gv    [2];
    logic [7:0]        seq   [2];
    logic [7:0]        hdr_c [2];
    logic [7:0]        len_c [2];
    logic [7:0]        csum_c[2];
    logic [15:0]       good  [2];
    logic              strobe[2];
    logic              gap   [2];
    logic              init  [2];
    logic              err   [2];

    spi_sensor_packet_rx #(
        .NUM_CH(NCH), .HEADER_BYTE(8'hAA), .SYNC_STAGES(SS), .CSUM_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sdi(sdi),
        .euler(euler[0]), .gyro(gyro[0]), .euler_valid(ev[0]), .gyro_valid(gv[0]),
        .seq_num(seq[0]), .pkt_strobe(strobe[0]), .seq_gap(gap[0]),
        .initialized(init[0]), .error(err[0]), .good_cnt(good[0]),
        .err_hdr_cnt(hdr_c[0]), .err_len_cnt(len_c[0]), .err_csum_cnt(csum_c[0])
    );

    spi_sensor_packet_rx #(
        .NUM_CH(NCH), .HEADER_BYTE(8'hAA), .SYNC_STAGES(SS), .CSUM_EN(1'b0)
    ) dut_nc (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sdi(sdi),
        .euler(euler[1]), .gyro(gyro[1]), .euler_valid(ev[1]), .gyro_valid(gv[1]),
        .seq_num(seq[1]), .pkt_strobe(strobe[1]), .seq_gap(gap[1]),
        .initialized(init[1]), .error(err[1]), .good_cnt(good[1]),
        .err_hdr_cnt(hdr_c[1]), .err_len_cnt(len_c[1]), .err_csum_cnt(csum_c[1])
    );

    // model state, index 0 = checksum enabled, 1 = checksum ignored
    logic [95:0] m_euler[2];
    logic [95:0] m_gyro [2];
    logic [1:0]  m_ev   [2];
    logic [1:0]  m_gv   [2];
    logic [7:0]  m_seq  [2];
    logic [7:0]  m_hdr  [2];
    logic [7:0]  m_len  [2];
    logic [7:0]  m_csum [2];
    logic [15:0] m_good [2];
    logic        m_init [2];
    logic        m_err  [2];

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    bit chk_en   = 1'b0;
    int st_cnt [2];
    int gap_cnt[2];
    int st_lat [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, inst, act, exp);
    endtask

    // Per-cycle compare of stable outputs; while a transaction is being
    // evaluated, count the pulses instead so they can be checked afterwards.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (chk_en) begin
                chk("euler",        i, 96'(euler[i]),  m_euler[i]);
                chk("gyro",         i, 96'(gyro[i]),   m_gyro[i]);
                chk("euler_valid",  i, 96'(ev[i]),     96'(m_ev[i]));
                chk("gyro_valid",   i, 96'(gv[i]),     96'(m_gv[i]));
                chk("seq_num",      i, 96'(seq[i]),    96'(m_seq[i]));
                chk("initialized",  i, 96'(init[i]),   96'(m_init[i]));
                chk("error",        i, 96'(err[i]),    96'(m_err[i]));
                chk("good_cnt",     i, 96'(good[i]),   96'(m_good[i]));
                chk("err_hdr_cnt",  i, 96'(hdr_c[i]),  96'(m_hdr[i]));
                chk("err_len_cnt",  i, 96'(len_c[i]),  96'(m_len[i]));
                chk("err_csum_cnt", i, 96'(csum_c[i]), 96'(m_csum[i]));
                chk("quiet pkt_strobe", i, 96'(strobe[i]), 96'(0));
                chk("quiet seq_gap",    i, 96'(gap[i]),    96'(0));
            end else begin
                if (strobe[i] === 1'b1) begin
                    st_cnt[i]++;
                    st_lat[i] = cyc - rise_cyc;
                end
                if (gap[i] === 1'b1) gap_cnt[i]++;
            end
        end
    end

    task automatic model_zero();
        for (int i = 0; i < 2; i++) begin
            m_euler[i] = '0; m_gyro[i] = '0; m_ev[i] = '0; m_gv[i] = '0;
            m_seq[i] = '0; m_hdr[i] = '0; m_len[i] = '0; m_csum[i] = '0;
            m_good[i] = '0; m_init[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    // Apply one finished transaction to the model and check the pulses it produced
    task automatic model_txn(input bq_t q, input int extra, input bit ignored);
        logic [7:0]  x;
        logic [15:0] roll, pitch, yaw, gx, gy, gz;
        int n, b, exp_st, exp_gap;
        n = q.size();
        x = '0;
        foreach (q[j]) x ^= q[j];
        for (int i = 0; i < 2; i++) begin
            exp_st  = 0;
            exp_gap = 0;
            if (!ignored) begin
                if (n == 0 || q[0] != 8'hAA) begin
                    m_err[i] = 1'b1;
                    if (m_hdr[i] != 8'd255) m_hdr[i]++;
                end else if (n != PB || extra != 0) begin
                    m_err[i] = 1'b1;
                    if (m_len[i] != 8'd255) m_len[i]++;
                end else if (i == 0 && x != 8'h00) begin
                    m_err[i] = 1'b1;
                    if (m_csum[i] != 8'd255) m_csum[i]++;
                end else begin
                    exp_st  = 1;
                    exp_gap = (m_init[i] && q[1] != 8'(m_seq[i] + 8'd1)) ? 1 : 0;
                    for (int k = 0; k < NCH; k++) begin
                        b     = 2 + 13 * k;
                        roll  = {q[b],    q[b+1]};
                        pitch = {q[b+2],  q[b+3]};
                        yaw   = {q[b+4],  q[b+5]};
                        gx    = {q[b+6],  q[b+7]};
                        gy    = {q[b+8],  q[b+9]};
                        gz    = {q[b+10], q[b+11]};
                        m_euler[i][48*k +: 48] = {roll, pitch, yaw};
                        m_gyro[i][48*k +: 48]  = {gx, gy, gz};
                        m_ev[i][k] = q[b+12][0];
                        m_gv[i][k] = q[b+12][1];
                    end
                    m_seq[i]  = q[1];
                    m_good[i] = m_good[i] + 16'd1;
                    m_init[i] = 1'b1;
                    m_err[i]  = 1'b0;
                end
            end
            chk("pkt_strobe count", i, 96'(st_cnt[i]),  96'(exp_st));
            chk("seq_gap count",    i, 96'(gap_cnt[i]), 96'(exp_gap));
            if (exp_st == 1)
                chk("commit latency in range", i,
                    96'((st_lat[i] >= SS + 2 && st_lat[i] <= SS + 4) ? 1 : 0), 96'(1));
        end
    endtask

    task automatic send_bit(input logic v);
        sdi = v;
        repeat (HALF) @(posedge clk);
        #2 sck = 1'b1;
        repeat (HALF) @(posedge clk);
        #2 sck = 1'b0;
    endtask

    // One CS-low transaction; rst_at = byte index at which to pulse reset (-1: none);
    // clash = raise sck together with cs_n at the end
    task automatic send_txn(input bq_t q, input int extra, input int rst_at, input bit clash);
        bit ignored;
        ignored = 1'b0;
        @(posedge clk);
        #2 cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        foreach (q[b]) begin
            if (b == rst_at) begin
                chk_en = 1'b0;
                rst_n  = 1'b0;
                model_zero();
                ignored = 1'b1;
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b1;
                chk_en = 1'b1;
            end
            for (int j = 7; j >= 0; j--) send_bit(q[b][j]);
        end
        for (int j = 0; j < extra; j++) send_bit(1'($urandom_range(0, 1)));
        repeat (3) @(posedge clk);
        #2;
        st_cnt  = '{0, 0};
        gap_cnt = '{0, 0};
        chk_en  = 1'b0;
        if (clash) begin
            sdi = 1'($urandom);
            repeat (HALF) @(posedge clk);
            #2 sck = 1'b1;
        end
        rise_cyc = cyc;
        cs_n     = 1'b1;
        repeat (SS + 8) @(posedge clk);
        #2 sck = 1'b0;
        model_txn(q, extra, ignored);
        chk_en = 1'b1;
    endtask

    function automatic bq_t with_csum(input bq_t q);
        logic [7:0] x;
        x = '0;
        foreach (q[i]) x ^= q[i];
        q.push_back(x);
        return q;
    endfunction

    function automatic bq_t rand_pkt(input logic [7:0] s);
        bq_t q;
        q.push_back(8'hAA);
        q.push_back(s);
        for (int i = 0; i < PB - 3; i++) q.push_back(8'($urandom));
        return with_csum(q);
    endfunction

    function automatic bq_t reseq(input bq_t q, input logic [7:0] s);
        q[1] = s;
        void'(q.pop_back());
        return with_csum(q);
    endfunction

    initial begin
        bq_t p, base;
        int  kind, extra;
        int  gap_exp[4];
        logic [7:0] seqs[4];

        model_zero();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk_en = 1'b1;
        chk("reset good_cnt", 0, 96'(good[0]), 96'(0));
        chk("reset euler", 0, 96'(euler[0]), 96'(0));

        // reference good packet
        base = {8'hAA, 8'h05, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h00, 8'h01,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h03};
        for (int i = 0; i < 6; i++) begin
            base.push_back(8'h80);
            base.push_back(8'h00);
        end
        base.push_back(8'h01);
        base = with_csum(base);
        send_txn(base, 0, -1, 1'b0);
        chk("good euler ch0",   0, 96'(euler[0][47:0]),  96'(48'h1234FF000001));
        chk("good euler ch1",   0, 96'(euler[0][95:48]), 96'(48'h800080008000));
        chk("good gyro ch0",    0, 96'(gyro[0][47:0]),   96'(48'h010203040506));
        chk("good euler_valid", 0, 96'(ev[0]),  96'(2'b11));
        chk("good gyro_valid",  0, 96'(gv[0]),  96'(2'b01));
        chk("good good_cnt",    0, 96'(good[0]), 96'(1));
        chk("good initialized", 0, 96'(init[0]), 96'(1));
        chk("good strobes",     0, 96'(st_cnt[0]), 96'(1));
        chk("good seq_gap",     0, 96'(gap_cnt[0]), 96'(0));

        // bad header, full length
        p = base;
        p[0] = 8'h55;
        send_txn(p, 0, -1, 1'b0);
        chk("badhdr err_hdr_cnt", 0, 96'(hdr_c[0]), 96'(1));
        chk("badhdr error",       0, 96'(err[0]),   96'(1));
        chk("badhdr good_cnt",    0, 96'(good[0]),  96'(1));

        // length errors: one byte short, then three extra bits
        p = base;
        void'(p.pop_back());
        send_txn(p, 0, -1, 1'b0);
        send_txn(base, 3, -1, 1'b0);
        chk("length err_len_cnt", 0, 96'(len_c[0]), 96'(2));
        chk("length good_cnt",    0, 96'(good[0]),  96'(1));

        // checksum bit 0 flipped: rejected with check, committed without
        p = base;
        p[PB-1] = p[PB-1] ^ 8'h01;
        send_txn(p, 0, -1, 1'b0);
        chk("csum err_csum_cnt", 0, 96'(csum_c[0]), 96'(1));
        chk("csum off commits",  1, 96'(good[1]),   96'(2));
        chk("csum off no err",   1, 96'(csum_c[1]), 96'(0));

        // sequence gaps after 0x05
        seqs    = '{8'h06, 8'h08, 8'hFF, 8'h00};
        gap_exp = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            send_txn(reseq(base, seqs[i]), 0, -1, 1'b0);
            chk("seq_gap pulse", 0, 96'(gap_cnt[0]), 96'(gap_exp[i]));
        end

        // cs release and sck edge together: the sck edge is dropped
        send_txn(reseq(base, 8'h01), 0, -1, 1'b1);
        chk("clash commits", 0, 96'(good[0]), 96'(6));

        // reset at byte 10 with cs_n low, then a fresh packet
        send_txn(reseq(base, 8'h02), 0, 10, 1'b0);
        chk("rst good_cnt",    0, 96'(good[0]),  96'(0));
        chk("rst err_len_cnt", 0, 96'(len_c[0]), 96'(0));
        send_txn(reseq(base, 8'h40), 0, -1, 1'b0);
        chk("post-rst good_cnt", 0, 96'(good[0]),    96'(1));
        chk("post-rst seq_gap",  0, 96'(gap_cnt[0]), 96'(0));
        chk("post-rst seq_num",  0, 96'(seq[0]),     96'(8'h40));

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            kind  = $urandom_range(0, 5);
            extra = 0;
            if ($urandom_range(0, 1) == 1) p = rand_pkt(8'(m_seq[0] + 8'd1));
            else                            p = rand_pkt(8'($urandom));
            case (kind)
                2: begin
                    p[0] = 8'($urandom);
                    if (p[0] == 8'hAA) p[0] = 8'h00;
                    repeat ($urandom_range(0, 20)) void'(p.pop_back());
                end
                3: begin
                    if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) void'(p.pop_back());
                    else repeat ($urandom_range(1, 3)) p.push_back(8'($urandom));
                end
                4: extra = $urandom_range(1, 7);
                5: p[$urandom_range(0, PB - 1)] ^= 8'(1 << $urandom_range(0, 7));
                default: ;
            endcase
            send_txn(p, extra, -1, 1'b0);
        end

        // short bad-header packets until the counter saturates
        for (int t = 0; t < 300; t++) begin
            p = {8'($urandom)};
            if (p[0] == 8'hAA) p[0] = 8'h55;
            send_txn(p, 0, -1, 1'b0);
        end
        chk("hdr saturation", 0, 96'(hdr_c[0]), 96'(255));
        chk("hdr saturation", 1, 96'(hdr_c[1]), 96'(255));

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
